sc_fir_ctrl: RTL
================

SC_FIR_CTRL -- requirements
Module: sc_fir_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning sample magnitude width; stochastic window = 2^N cycles.
REQ-002 SHALL have parameter LENGTH, default 19, meaning number of FIR taps (filter order + 1).
REQ-003 SHALL have parameter LEN_IDX, default 5, meaning width of the fill counter, ceil(log2(LENGTH)).
REQ-004 SHALL have port clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit, meaning synchronous abort and delay-line clear request.
REQ-007 SHALL have ports in_data (input, N+1), in_valid (input, 1) and in_ready (output, 1), meaning binary input sample with valid/ready handshake.
REQ-008 SHALL have port sample, output, N+1 bits, meaning the latched sample held stable to the SNG for the whole window.
REQ-009 SHALL have port sng_cnt, output, N bits, meaning the window cycle index, 0..2^N-1.
REQ-010 SHALL have ports shift_en, acc_clr, acc_en and dl_clr, outputs, 1 bit each, meaning delay-line advance, BC accumulator clear, BC accumulator count enable and delay-line clear.
REQ-011 SHALL have port bc_in, input, (N+1)*4 bits, meaning the datapath's back-converted binary result.
REQ-012 SHALL have ports out_data (output, (N+1)*4), out_primed (output, 1), out_valid (output, 1) and out_ready (input, 1), meaning the result, the result's primed flag, and the output handshake.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, CAPTURE and HOLD, with Moore outputs decoded from state.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, latch in_data into sample and go to LOAD; sample SHALL stay unchanged until the next accepted handshake.
REQ-016 SHALL, in LOAD (exactly 1 cycle), assert shift_en=1 and acc_clr=1, increment the fill counter saturating at LENGTH, clear sng_cnt to 0, and go to RUN.
REQ-017 SHALL, in RUN, assert acc_en=1 and increment sng_cnt each cycle from 0 to 2^N-1; at sng_cnt==2^N-1 it SHALL go to CAPTURE, with sng_cnt wrapping to 0.
REQ-018 SHALL, in CAPTURE (1 cycle, acc_en=0), register out_data<=bc_in and out_primed<=(fill==LENGTH), then go to HOLD.
REQ-019 SHALL, in HOLD, drive out_valid=1 with out_data and out_primed stable until out_valid&&out_ready, then go to IDLE.
REQ-020 SHALL give a latency from the input handshake at edge T to out_valid=1 of exactly 2^N+3 cycles (259 at N=8).
REQ-021 SHALL ignore in_valid outside IDLE; the sample SHALL NOT be overwritten.
REQ-022 SHALL, when out_ready is held high, return to IDLE the cycle after HOLD is entered, giving a 2^N+4 cycle throughput per sample.
REQ-023 SHALL treat flush=1 in any state as taking priority over every other transition: the next state is IDLE, fill=0, out_valid=0, sng_cnt=0, and dl_clr=1 for that one cycle; a result in progress is discarded.
REQ-024 SHALL keep shift_en, acc_clr and acc_en mutually exclusive in any cycle.
REQ-025 SHALL keep fill at LENGTH once it is reached; it SHALL NOT wrap.

Reset
REQ-026 SHALL, on reset=1, immediately (asynchronously) force state=IDLE, sample=0, sng_cnt=0, fill=0, out_data=0, out_primed=0, out_valid=0, and shift_en, acc_clr, acc_en and dl_clr all 0.
REQ-027 SHALL, when reset is asserted mid-RUN, abandon the window with no out_valid pulse, and after release SHALL accept a new sample in IDLE.

Verification
REQ-028 SHALL cover: reset released, in_data=9'h003 with in_valid pulsed at T -> shift_en and acc_clr high at T+1; acc_en high T+2..T+257; out_valid rising at T+259; out_data equal to bc_in sampled in CAPTURE.
REQ-029 SHALL cover: 19 back-to-back samples with out_ready=1 -> out_primed=0 for results 1..18 and 1 for result 19 and every later result.
REQ-030 SHALL cover: out_ready=0 for 50 cycles in HOLD while in_valid=1 -> out_data stable, in_ready=0, no extra shift_en; after out_ready=1, in_ready=1 on the next cycle.
REQ-031 SHALL cover: flush at sng_cnt=100 -> dl_clr pulse for 1 cycle, next state IDLE, no out_valid, fill=0, and the next result has out_primed=0.
REQ-032 SHALL cover: asynchronous reset asserted mid-RUN between clock edges -> all outputs 0 before the next edge; normal operation after release.
REQ-033 SHALL cover: sng_cnt monitored over one window -> takes every value 0..255 exactly once, in order, while acc_en=1.

Source files
------------

// File: rtl/sc_fir_ctrl.sv
// sc_fir_ctrl: sequencer for a stochastic-computing FIR filter.
// It accepts one binary sample, advances the delay line and runs one
// 2^N-cycle stochastic window. It then captures the back-converted result
// and holds it on a valid/ready output port until the result is taken.
module sc_fir_ctrl #(
    parameter int N       = 8,
    parameter int LENGTH  = 19,
    parameter int LEN_IDX = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [N:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N:0]           sample,
    output logic [N-1:0]         sng_cnt,
    output logic                 shift_en,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic                 dl_clr,
    input  logic [(N+1)*4-1:0]   bc_in,
    output logic [(N+1)*4-1:0]   out_data,
    output logic                 out_primed,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [N:0]            sample_q;
    logic [N-1:0]          cnt_q;
    logic [LEN_IDX-1:0]    fill_q;
    logic [(N+1)*4-1:0]    out_data_q;
    logic                  primed_q;
    logic                  dl_clr_q;

    logic fill_full;
    assign fill_full = (fill_q == LEN_IDX'(LENGTH));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and Moore output decode; flush overrides every transition.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = LOAD;
            end
            LOAD: begin
                shift_en = 1'b1;
                acc_clr  = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                acc_en = 1'b1;
                if (cnt_q == '1) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath registers: sample latch, window counter, fill counter, result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q   <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            out_data_q <= '0;
            primed_q   <= 1'b0;
            dl_clr_q   <= 1'b0;
        end else begin
            dl_clr_q <= flush;
            if (flush) begin
                cnt_q  <= '0;
                fill_q <= '0;
            end else begin
                case (state_q)
                    IDLE: if (in_valid) sample_q <= in_data;
                    LOAD: begin
                        cnt_q <= '0;
                        if (!fill_full) fill_q <= fill_q + LEN_IDX'(1);
                    end
                    RUN: cnt_q <= cnt_q + N'(1);
                    CAPTURE: begin
                        out_data_q <= bc_in;
                        primed_q   <= fill_full;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sample     = sample_q;
    assign sng_cnt    = cnt_q;
    assign dl_clr     = dl_clr_q;
    assign out_data   = out_data_q;
    assign out_primed = primed_q;

endmodule
